// File: rtl/jtag_host_master.sv
// JTAG initiator: turns TAP-reset / IR-scan / DR-scan commands into TCK/TMS/TDI
// bit slots and returns the TDO bits captured during the shift phase.
module jtag_host_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DR_MAX  = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [6:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              jtag_TCK,
    output logic              jtag_TMS,
    output logic              jtag_TDI,
    input  logic              jtag_TDO
);

    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {AUTO_RST, IDLE, PRE, SHIFT, POST, RESP} state_t;

    state_t            state;
    logic [PW-1:0]     phase;
    logic [6:0]        cnt;
    logic [6:0]        len;
    logic              is_ir;
    logic              from_cmd;
    logic [DR_MAX-1:0] sr;
    logic              slot_end;
    logic [6:0]        len_clamp;

    assign slot_end  = (phase == PH_LAST);
    assign len_clamp = (cmd_len > 7'(DR_MAX)) ? 7'(DR_MAX) : cmd_len;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= AUTO_RST;
            phase     <= '0;
            cnt       <= '0;
            len       <= '0;
            is_ir     <= 1'b0;
            from_cmd  <= 1'b0;
            sr        <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            jtag_TCK  <= 1'b0;
            jtag_TMS  <= 1'b1;
            jtag_TDI  <= 1'b0;
        end else begin
            if (state inside {AUTO_RST, PRE, SHIFT, POST}) begin
                phase <= slot_end ? '0 : phase + 1'b1;
                if (phase == PH_HI) jtag_TCK <= 1'b1;
                if (slot_end)       jtag_TCK <= 1'b0;
            end
            // Each branch below runs at the end of a slot and sets TMS/TDI for the next one.
            case (state)
                AUTO_RST: if (slot_end) begin
                    if (cnt == 7'd5) begin
                        jtag_TMS <= 1'b0;
                        from_cmd <= 1'b0;
                        if (from_cmd) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        cnt      <= cnt + 7'd1;
                        jtag_TMS <= (cnt < 7'd4);
                    end
                end
                IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    cnt       <= '0;
                    phase     <= '0;
                    len       <= len_clamp;
                    is_ir     <= (cmd_type == 2'd1);
                    from_cmd  <= (cmd_type == 2'd0);
                    sr        <= cmd_data;
                    rsp_data  <= '0;
                    if (cmd_type == 2'd0) begin
                        state    <= AUTO_RST;
                        jtag_TMS <= 1'b1;
                    end else if (cmd_type == 2'd3 || len_clamp == 7'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        state    <= PRE;
                        jtag_TMS <= 1'b1;
                    end
                end
                PRE: if (slot_end) begin
                    if (cnt == (is_ir ? 7'd3 : 7'd2)) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        jtag_TDI <= sr[0];
                        jtag_TMS <= (len == 7'd1);
                    end else begin
                        cnt      <= cnt + 7'd1;
                        jtag_TMS <= is_ir && (cnt == 7'd0);
                    end
                end
                // TDO enters at the top while TDI bits leave at the bottom; the
                // captured bits are right-aligned when the response is posted.
                SHIFT: if (slot_end) begin
                    sr <= {jtag_TDO, sr[DR_MAX-1:1]};
                    if (cnt == len - 7'd1) begin
                        state    <= POST;
                        cnt      <= '0;
                        jtag_TMS <= 1'b1;
                        jtag_TDI <= 1'b0;
                    end else begin
                        cnt      <= cnt + 7'd1;
                        jtag_TDI <= sr[1];
                        jtag_TMS <= (cnt == len - 7'd2);
                    end
                end
                POST: if (slot_end) begin
                    if (cnt == 7'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= sr >> (7'(DR_MAX) - len);
                    end else begin
                        cnt      <= cnt + 7'd1;
                        jtag_TMS <= 1'b0;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= AUTO_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_master.sv
// Bench for jtag_host_master: a behavioural TAP target on the pins plus a
// bit-stream reference model that predicts responses and TAP register contents.
module tb_jtag_host_master;

    localparam int CLK_DIV = 2;
    localparam int DR_MAX  = 64;
    localparam logic [31:0] USER_INIT = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'd0;
    logic [6:0]  cmd_len = 7'd0;
    logic [63:0] cmd_data = '0;
    logic        rsp_ready = 1'b0;
    logic        cmd_ready, rsp_valid;
    logic [63:0] rsp_data;
    logic        jtag_TCK, jtag_TMS, jtag_TDI;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;

    tap_t        tap_st   = SHIR;
    logic [4:0]  tap_ir   = 5'h1F;
    logic [4:0]  tap_irsr = 5'h0;
    logic [31:0] tap_user = USER_INIT;
    logic [31:0] tap_drsr = 32'h0;
    logic        tap_tdo  = 1'b0;

    jtag_host_master #(.CLK_DIV(CLK_DIV), .DR_MAX(DR_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(tap_tdo)
    );

    function automatic tap_t tap_next(tap_t s, logic tms);
        case (s)
            TLR:     return tms ? TLR   : RTI;
            RTI:     return tms ? SELDR : RTI;
            SELDR:   return tms ? SELIR : CAPDR;
            CAPDR:   return tms ? EX1DR : SHDR;
            SHDR:    return tms ? EX1DR : SHDR;
            EX1DR:   return tms ? UPDR  : PADR;
            PADR:    return tms ? EX2DR : PADR;
            EX2DR:   return tms ? UPDR  : SHDR;
            UPDR:    return tms ? SELDR : RTI;
            SELIR:   return tms ? TLR   : CAPIR;
            CAPIR:   return tms ? EX1IR : SHIR;
            SHIR:    return tms ? EX1IR : SHIR;
            EX1IR:   return tms ? UPIR  : PAIR;
            PAIR:    return tms ? EX2IR : PAIR;
            EX2IR:   return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    // Target TAP: IR 0x1F selects a 1-bit bypass, any other IR a 32-bit user register.
    always @(posedge jtag_TCK) begin
        case (tap_st)
            TLR:   tap_ir   <= 5'h01;
            CAPDR: tap_drsr <= (tap_ir == 5'h1F) ? 32'h0 : tap_user;
            SHDR:  tap_drsr <= (tap_ir == 5'h1F) ? {31'h0, jtag_TDI} : {jtag_TDI, tap_drsr[31:1]};
            UPDR:  if (tap_ir != 5'h1F) tap_user <= tap_drsr;
            CAPIR: tap_irsr <= 5'b00001;
            SHIR:  tap_irsr <= {jtag_TDI, tap_irsr[4:1]};
            UPIR:  tap_ir   <= tap_irsr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, jtag_TMS);
    end

    always @(negedge jtag_TCK) begin
        if (tap_st == SHDR)      tap_tdo <= tap_drsr[0];
        else if (tap_st == SHIR) tap_tdo <= tap_irsr[0];
    end

    logic tms_q[$];
    int   tck_hi = 0;
    always @(posedge jtag_TCK) tms_q.push_back(jtag_TMS);
    always @(negedge clk) if (jtag_TCK) tck_hi++;

    logic [4:0]  m_ir   = 5'h01;
    logic [31:0] m_user = USER_INIT;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge right after a clk edge that saw rstn = 0.
    task automatic reset_seq(input string tag);
        logic [127:0] o_tms, o_tck, e_tms, e_tck;
        bit early;
        o_tms = '0; o_tck = '0; e_tms = '0; e_tck = '0; early = 1'b0;
        rstn = 1'b1;
        for (int c = 0; c < 12 * CLK_DIV; c++) begin
            o_tms[c] = jtag_TMS;
            o_tck[c] = jtag_TCK;
            e_tms[c] = (c / (2 * CLK_DIV)) < 5;
            e_tck[c] = (c % (2 * CLK_DIV)) >= CLK_DIV;
            if (cmd_ready || rsp_valid) early = 1'b1;
            @(negedge clk);
        end
        check_eq({tag, "_tms"}, o_tms, e_tms);
        check_eq({tag, "_tck"}, o_tck, e_tck);
        check_eq({tag, "_early_hs"}, 128'(early), 128'd0);
        check_eq({tag, "_ready"}, 128'(cmd_ready), 128'd1);
        check_eq({tag, "_tap_state"}, 128'(tap_st), 128'(RTI));
        check_eq({tag, "_tap_ir"}, 128'(tap_ir), 128'h01);
        m_ir = 5'h01;
    endtask

    // Called at a negedge; returns at a negedge one cycle after the response handshake.
    task automatic run_cmd(input logic [1:0] t, input int l, input logic [63:0] d,
                           input int hold, input bit keep);
        logic [127:0] e_tms, o_tms, stream, e_rsp, reg0;
        logic [63:0]  held;
        int le, n, p, cyc, t0, h0, wt;
        bit bad;
        le = (l > DR_MAX) ? DR_MAX : l;
        e_tms = '0; e_rsp = '0; p = 0; n = 0; reg0 = '0; stream = '0;
        if (t == 2'd0) begin
            for (int k = 0; k < 6; k++) e_tms[k] = (k < 5);
            p = 6;
            m_ir = 5'h01;
        end else if (t != 2'd3 && le > 0) begin
            if (t == 2'd1) begin
                n = 5; reg0 = 128'h01; e_tms[0] = 1'b1; e_tms[1] = 1'b1; p = 4;
            end else begin
                n = (m_ir == 5'h1F) ? 1 : 32;
                reg0 = (n == 1) ? '0 : 128'(m_user);
                e_tms[0] = 1'b1; p = 3;
            end
            // Bits leave the target register first, then the TDI bits follow them.
            stream = reg0 | (128'(d) << n);
            e_rsp  = stream & ((128'd1 << le) - 128'd1);
            for (int k = 0; k < le; k++) e_tms[p + k] = (k == le - 1);
            p = p + le;
            e_tms[p] = 1'b1;
            p = p + 2;
            if (t == 2'd1)   m_ir   = 5'(stream >> le);
            else if (n == 32) m_user = 32'(stream >> le);
        end

        wt = 0;
        while (!cmd_ready && wt < 1000) begin @(negedge clk); wt++; end
        check_eq("ready_wait", 128'(wt < 1000), 128'd1);
        check_eq("idle_pins", 128'({jtag_TCK, jtag_TMS, jtag_TDI}), 128'd0);
        t0 = tms_q.size(); h0 = tck_hi;
        cmd_type = t; cmd_len = 7'(l); cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("ready_drop", 128'(cmd_ready), 128'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 2000) begin @(negedge clk); cyc++; end
        check_eq("latency", 128'(cyc), 128'(p * 2 * CLK_DIV));
        check_eq("rsp_data", 128'(rsp_data), e_rsp);
        check_eq("tck_pulses", 128'(tms_q.size() - t0), 128'(p));
        o_tms = '0;
        for (int k = 0; k < tms_q.size() - t0 && k < 128; k++) o_tms[k] = tms_q[t0 + k];
        check_eq("tms_seq", o_tms, e_tms);
        check_eq("tck_high", 128'(tck_hi - h0), 128'(p * CLK_DIV));

        held = rsp_data; bad = 1'b0;
        if (keep) begin cmd_valid = 1'b1; cmd_type = 2'd3; cmd_len = 7'd0; end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_data !== held || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad = 1'b1;
        end
        if (hold > 0) check_eq("rsp_hold", 128'(bad), 128'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check_eq("rsp_release", 128'({rsp_valid, cmd_ready}), 128'b01);
        check_eq("tap_state", 128'(tap_st), 128'(RTI));
        check_eq("tap_ir", 128'(tap_ir), 128'(m_ir));
        if (t == 2'd2) check_eq("tap_user", 128'(tap_user), 128'(m_user));
    endtask

    initial begin
        logic [1:0] t;
        int r, t0, wt;
        repeat (3) @(negedge clk);
        reset_seq("por");

        run_cmd(2'd1, 5, 64'h1F, 0, 1'b0);
        run_cmd(2'd2, 8, 64'hA5, 0, 1'b0);
        run_cmd(2'd1, 5, 64'h01, 0, 1'b0);
        run_cmd(2'd2, 0, 64'hFFFF, 0, 1'b0);
        run_cmd(2'd2, 32, 64'h1234_5678_9ABC_DEF0, 10, 1'b1);
        run_cmd(2'd2, 32, 64'h0F0F_3C3C, 2, 1'b0);
        run_cmd(2'd2, 100, {$urandom, $urandom}, 1, 1'b0);
        run_cmd(2'd3, 20, 64'hFF, 1, 1'b0);
        run_cmd(2'd0, 0, 64'h0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            t = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 5) ? 2'd1 : 2'd2;
            run_cmd(t, $urandom_range(0, 80), {$urandom, $urandom},
                    $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
        end

        // Reset in the middle of a 32-bit DR scan, during shift slot 3.
        wt = 0;
        while (!cmd_ready && wt < 1000) begin @(negedge clk); wt++; end
        t0 = tms_q.size();
        cmd_type = 2'd2; cmd_len = 7'd32; cmd_data = {$urandom, $urandom}; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wt = 0;
        while ((tms_q.size() - t0) < 7 && wt < 1000) begin @(negedge clk); wt++; end
        check_eq("mid_reach_slot3", 128'(wt < 1000), 128'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_pins", 128'({jtag_TCK, jtag_TMS, jtag_TDI, rsp_valid, cmd_ready}), 128'b01000);
        reset_seq("mid");
        run_cmd(2'd1, 5, 64'h1F, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
